// File: rtl/fib_buffer_if.sv
// Handshake bundle between a Fibonacci term generator, the fib_buffer FIFO and its consumer.
// Signal prefixes are written from the buffer's point of view: i_ = into the buffer, o_ = out of it.
interface fib_buffer_if;
  logic        i_start;
  logic        i_stop;
  logic [7:0]  i_n_terms;
  logic        o_gen_en;
  logic        i_in_valid;
  logic [15:0] i_in_data;
  logic        o_out_valid;
  logic [15:0] o_out_data;
  logic        i_out_ready;
  logic [4:0]  o_count;
  logic        o_busy;
  logic        o_done;
  logic        o_ovf;
  logic        o_drop_err;

  modport master (
    output i_start, i_stop, i_n_terms, i_in_valid, i_in_data, i_out_ready,
    input  o_gen_en, o_out_valid, o_out_data, o_count, o_busy, o_done, o_ovf, o_drop_err
  );

  modport slave (
    input  i_start, i_stop, i_n_terms, i_in_valid, i_in_data, i_out_ready,
    output o_gen_en, o_out_valid, o_out_data, o_count, o_busy, o_done, o_ovf, o_drop_err
  );
endinterface

// File: rtl/fib_buffer.sv
// Collects n_terms Fibonacci terms from an upstream generator into a show-ahead FIFO,
// throttling the generator when full and flagging 16-bit wrap and dropped terms.
//   state | meaning
//   IDLE  | waiting for start with non-zero n_terms
//   RUN   | generator enabled, collecting terms
//   DRAIN | collection finished, emptying FIFO
module fib_buffer #(
  parameter int DEPTH = 8
) (
  input logic       clk,
  input logic       rst,
  fib_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_done;

  logic [15:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [4:0]  r_count;
  logic [7:0]  r_n_terms;
  logic [7:0]  r_push_cnt;
  logic [15:0] r_last;
  logic        r_has_last;
  logic        r_ovf;
  logic        r_drop_err;

  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_start;
  logic        w_last_push;

  assign w_full      = (r_count == 5'(DEPTH));
  assign w_push      = bus.i_in_valid && !w_full;
  assign w_pop       = (r_count != 5'd0) && bus.i_out_ready;
  assign w_start     = (r_state == S_IDLE) && bus.i_start && (bus.i_n_terms != 8'd0);
  assign w_last_push = (r_state == S_RUN) && w_push && ((r_push_cnt + 8'd1) == r_n_terms);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_RUN;
      S_RUN:   if (bus.i_stop || w_last_push) w_next = S_DRAIN;
      S_DRAIN: begin
        // a term still arriving this cycle keeps us draining
        if ((r_count == 5'd0) && !w_push) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 5'd0;
      r_n_terms  <= 8'd0;
      r_push_cnt <= 8'd0;
      r_last     <= 16'd0;
      r_has_last <= 1'b0;
      r_ovf      <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase

      if (w_start) begin
        r_n_terms  <= bus.i_n_terms;
        r_push_cnt <= 8'd0;
        r_last     <= 16'd0;
        r_has_last <= 1'b0;
        r_ovf      <= 1'b0;
        r_drop_err <= 1'b0;
      end else begin
        if (w_push) begin
          // a decreasing term means the 16-bit sum wrapped
          if (r_has_last && (bus.i_in_data < r_last)) r_ovf <= 1'b1;
          r_last     <= bus.i_in_data;
          r_has_last <= 1'b1;
          if (r_state == S_RUN) r_push_cnt <= r_push_cnt + 8'd1;
        end
        if (bus.i_in_valid && w_full) r_drop_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.i_in_data;
  end

  assign bus.o_gen_en    = (r_state == S_RUN) && !w_full;
  assign bus.o_out_valid = (r_count != 5'd0);
  assign bus.o_out_data  = r_mem[r_rd_ptr];
  assign bus.o_count     = r_count;
  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_done      = w_done;
  assign bus.o_ovf       = r_ovf;
  assign bus.o_drop_err  = r_drop_err;
endmodule

// File: tb/tb_fib_buffer.sv
// Randomized episodes of start/collect/drain against a queue-based reference of the buffer.
module tb_fib_buffer;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  fib_buffer_if bus ();

  fib_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: phase 0 = idle, 1 = collecting, 2 = draining
  int          m_phase;
  logic [15:0] m_q[$];
  int          m_n;
  int          m_pc;
  bit          m_ovf;
  bit          m_drop;
  bit          m_has_last;
  logic [15:0] m_last;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_q.delete();
    m_n = 0;
    m_pc = 0;
    m_ovf = 0;
    m_drop = 0;
    m_has_last = 0;
    m_last = '0;
  endtask

  task automatic compare();
    int cnt;
    bit push;
    cnt  = m_q.size();
    push = bus.i_in_valid && (cnt < DEPTH);
    check("count", 32'(bus.o_count), 32'(cnt));
    check("gen_en", 32'(bus.o_gen_en), 32'(m_phase == 1 && cnt < DEPTH));
    check("out_valid", 32'(bus.o_out_valid), 32'(cnt != 0));
    if (cnt != 0) check("out_data", 32'(bus.o_out_data), 32'(m_q[0]));
    check("busy", 32'(bus.o_busy), 32'(m_phase != 0));
    check("done", 32'(bus.o_done), 32'(m_phase == 2 && cnt == 0 && !push));
    check("ovf", 32'(bus.o_ovf), 32'(m_ovf));
    check("drop_err", 32'(bus.o_drop_err), 32'(m_drop));
  endtask

  task automatic model_update();
    int cnt;
    bit push;
    bit pop;
    logic [15:0] d;
    cnt  = m_q.size();
    push = bus.i_in_valid && (cnt < DEPTH);
    pop  = (cnt != 0) && bus.i_out_ready;
    d    = bus.i_in_data;
    if (m_phase == 0 && bus.i_start && bus.i_n_terms != 0) begin
      m_phase = 1;
      m_n = int'(bus.i_n_terms);
      m_pc = 0;
      m_ovf = 0;
      m_drop = 0;
      m_has_last = 0;
    end else begin
      if (push) begin
        if (m_has_last && d < m_last) m_ovf = 1;
        m_last = d;
        m_has_last = 1;
        if (m_phase == 1) m_pc++;
      end
      if (bus.i_in_valid && cnt == DEPTH) m_drop = 1;
      if (m_phase == 1 && (bus.i_stop || (push && m_pc == m_n))) m_phase = 2;
      else if (m_phase == 2 && cnt == 0 && !push) m_phase = 0;
    end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(d);
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_count"}, 32'(bus.o_count), 32'd0);
    check({tag, "_out_valid"}, 32'(bus.o_out_valid), 32'd0);
    check({tag, "_gen_en"}, 32'(bus.o_gen_en), 32'd0);
    check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    check({tag, "_done"}, 32'(bus.o_done), 32'd0);
    check({tag, "_ovf"}, 32'(bus.o_ovf), 32'd0);
    check({tag, "_drop_err"}, 32'(bus.o_drop_err), 32'd0);
  endtask

  initial begin
    logic [15:0] f_a;
    logic [15:0] f_b;
    logic [15:0] f_t;
    int n;
    int p_ready;
    int p_valid;
    int hold_ready;
    int stop_p;
    int reset_at;
    bit force_valid;
    bit rand_data;
    bit did_reset;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_stop = 1'b0;
    bus.i_n_terms = 8'd0;
    bus.i_in_valid = 1'b0;
    bus.i_in_data = 16'd0;
    bus.i_out_ready = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("por");
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int ep = 0; ep < 48; ep++) begin
      if (ep == 0) begin
        n = 5; p_ready = 100; p_valid = 100; hold_ready = 0;
        stop_p = 0; reset_at = -1; force_valid = 0; rand_data = 0;
      end else begin
        n           = (ep % 7 == 0) ? 0 : int'($urandom_range(1, 40));
        p_ready     = (ep % 3 == 0) ? 100 : ((ep % 3 == 1) ? 60 : 20);
        p_valid     = (ep % 2 == 0) ? 100 : 70;
        hold_ready  = (ep % 4 == 1) ? 40 : 0;
        stop_p      = (ep % 6 == 4) ? 4 : 0;
        reset_at    = (ep % 8 == 5) ? int'($urandom_range(3, 15)) : -1;
        force_valid = (ep % 3 == 2);
        rand_data   = (ep % 5 == 3);
      end

      f_a = 16'd0;
      f_b = 16'd1;
      bus.i_start = 1'b1;
      bus.i_n_terms = 8'(n);
      bus.i_in_valid = 1'b0;
      bus.i_stop = 1'b0;
      bus.i_out_ready = ($urandom_range(99) < 50);
      tick();
      bus.i_start = 1'b0;
      bus.i_n_terms = 8'($urandom);

      did_reset = 0;
      for (int cyc = 0; cyc < 800 && m_phase != 0; cyc++) begin
        bus.i_in_valid = (bus.o_gen_en && ($urandom_range(99) < p_valid)) ||
                         (force_valid && ($urandom_range(99) < 10));
        bus.i_in_data  = rand_data ? 16'($urandom) : f_a;
        bus.i_stop     = (m_phase == 1) && ($urandom_range(99) < stop_p);
        bus.i_out_ready = (cyc >= hold_ready) && ($urandom_range(99) < p_ready);
        tick();
        if (bus.i_in_valid) begin
          f_t = f_a + f_b;
          f_a = f_b;
          f_b = f_t;
        end
        if (cyc == reset_at) begin
          rst = 1'b1;
          #2;
          check_reset_outputs("midrun_rst");
          model_reset();
          #1;
          rst = 1'b0;
          did_reset = 1;
        end
      end
      bus.i_in_valid = 1'b0;
      bus.i_stop = 1'b0;
      bus.i_out_ready = 1'b0;
      tick();
      check("episode_end_busy", 32'(bus.o_busy), 32'd0);
      if (m_phase != 0) begin
        $display("FAIL episode_timeout: episode %0d still busy", ep);
        n_err++;
        model_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
